// File: rtl/struct_serializer.sv
// rtl/struct_serializer.sv - FIFO-buffered 64-bit struct to 32-bit word serializer (optional checksum: STRUCT_SERIALIZER_CHECKSUM_EN)
module struct_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_struct,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_int,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
    , SEND_C
`endif
  } state_t;

  state_t          state;
  logic [63:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level_next;
  logic [63:0]     head;
  logic            push;
  logic            pop;
  logic            last_xfer;
  logic [31:0]     hold_b;
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
  logic [31:0]     hold_a;
`endif

  assign head      = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign last_xfer = out_valid & out_ready & out_last;

  // Pop when idle with data waiting, or when the final word of a struct leaves and another is queued
  always_comb begin
    pop = 1'b0;
    if (level != '0) begin
      if (state == IDLE) pop = 1'b1;
      else if (last_xfer) pop = 1'b1;
    end
  end

  // Occupancy after this edge; a simultaneous push and pop cancel out
  always_comb begin
    level_next = level;
    if (push && !pop)      level_next = level + LW'(1);
    else if (!push && pop) level_next = level - LW'(1);
  end

  // FIFO storage is written only on an accepted push; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_struct;
  end

  // FIFO pointers, level and registered in_ready; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_next;
      in_ready <= (level_next < LW'(DEPTH));
    end
  end

  // Serializer FSM with registered word outputs; loading a new struct takes priority so streaming has no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_b    <= '0;
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
      hold_a    <= '0;
`endif
      out_valid <= 1'b0;
      out_int   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (pop) begin
      state     <= SEND_A;
      hold_b    <= head[31:0];
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
      hold_a    <= head[63:32];
`endif
      out_valid <= 1'b1;
      out_int   <= head[63:32];
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
    end else if (last_xfer) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_int   <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
    end else if (out_valid && out_ready) begin
      case (state)
        SEND_A: begin
          state   <= SEND_B;
          out_int <= hold_b;
          out_idx <= 2'd1;
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
          out_last <= 1'b0;
`else
          out_last <= 1'b1;
`endif
        end
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
        SEND_B: begin
          state    <= SEND_C;
          out_int  <= hold_a ^ hold_b;
          out_idx  <= 2'd2;
          out_last <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_struct_serializer.sv
// tb/tb_struct_serializer.sv - scoreboard bench for struct_serializer (DEPTH=4, either checksum build)
module tb_struct_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_struct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [2:0]  level;

`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
  localparam int   WPS        = 3;
  localparam logic EXP_LAST_B = 1'b0;
`else
  localparam int   WPS        = 2;
  localparam logic EXP_LAST_B = 1'b1;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  idx;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  int trk = 0;
  int cyc, first_v, last_v, v_cnt, lvl_max, rdy_low;

  always #5 clk = ~clk;

  struct_serializer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_struct (in_struct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .level     (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_struct(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back('{d: a, idx: 2'd0, last: 1'b0});
    exp_q.push_back('{d: b, idx: 2'd1, last: EXP_LAST_B});
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
    exp_q.push_back('{d: a ^ b, idx: 2'd2, last: 1'b1});
`endif
  endtask

  // Called at posedge+1; presents the struct across the next edge
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic acc);
    in_struct = {a, b};
    in_valid  = 1'b1;
    check("in_ready_at_push", {31'd0, in_ready}, {31'd0, acc});
    if (acc) expect_struct(a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_done", {31'd0, exp_q.size() == 0}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every transferred word against the scoreboard and gather streaming statistics
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h idx %0d, expected no word at %0t", out_int, out_idx, $time);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("word_data", out_int, w.d);
        check("word_idx", {30'd0, out_idx}, {30'd0, w.idx});
        check("word_last", {31'd0, out_last}, {31'd0, w.last});
      end
    end
    if (trk != 0) begin
      cyc++;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        v_cnt++;
      end
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (!in_ready) rdy_low = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_struct = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_int", out_int, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // Single struct {0,1}: first word one cycle after the push edge
    push(32'h0, 32'h1, 1'b1);
    check("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
    check("lat_level", {29'd0, level}, 32'd1);
    @(posedge clk); #1;
    check("lat_a_valid", {31'd0, out_valid}, 32'd1);
    check("lat_a_data", out_int, 32'h0);
    check("lat_a_idx", {30'd0, out_idx}, 32'd0);
    @(posedge clk); #1;
    check("lat_b_valid", {31'd0, out_valid}, 32'd1);
    check("lat_b_data", out_int, 32'h1);
    check("lat_b_last", {31'd0, out_last}, {31'd0, EXP_LAST_B});
    @(posedge clk); #1;
`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
    check("lat_c_idx", {30'd0, out_idx}, 32'd2);
`else
    check("lat_idle_after_b", {31'd0, out_valid}, 32'd0);
`endif
    drain();

    // Four back-to-back structs with out_ready high: no bubble, shallow level
    cyc = 0; first_v = -1; last_v = -1; v_cnt = 0; lvl_max = 0; rdy_low = 0;
    trk = 1;
    push(32'h11111111, 32'h22222222, 1'b1);
    push(32'h33333333, 32'h44444444, 1'b1);
    push(32'h55555555, 32'h66666666, 1'b1);
    push(32'h77777777, 32'h88888888, 1'b1);
    drain();
    trk = 0;
    check("b2b_word_count", v_cnt, 4 * WPS);
    check("b2b_no_bubble_span", last_v - first_v, 4 * WPS - 1);
    check("b2b_level_peak_le3", {31'd0, lvl_max <= 3}, 32'd1);
    check("b2b_in_ready_low_seen", rdy_low, 32'd0);

    // Stalled output: first struct goes to the holding register, next four fill the FIFO, sixth is dropped
    out_ready = 1'b0;
    push(32'hA0000000, 32'hB0000000, 1'b1);
    push(32'hA0000001, 32'hB0000001, 1'b1);
    push(32'hA0000002, 32'hB0000002, 1'b1);
    push(32'hA0000003, 32'hB0000003, 1'b1);
    push(32'hA0000004, 32'hB0000004, 1'b1);
    check("full_level", {29'd0, level}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    push(32'hDEAD0005, 32'hDEAD0005, 1'b0);
    check("full_level_after_drop", {29'd0, level}, 32'd4);
    check("full_head_word", out_int, 32'hA0000000);
    out_ready = 1'b1;
    drain();

    // Stall during the b word: outputs hold steady
    push(32'hDEADBEEF, 32'h12345678, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_int, 32'h12345678);
      check("stall_idx", {30'd0, out_idx}, 32'd1);
      check("stall_last", {31'd0, out_last}, {31'd0, EXP_LAST_B});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset while presenting word a with two structs queued
    out_ready = 1'b0;
    push(32'hC0000000, 32'hD0000000, 1'b1);
    push(32'hC0000001, 32'hD0000001, 1'b1);
    push(32'hC0000002, 32'hD0000002, 1'b1);
    check("pre_rst_level", {29'd0, level}, 32'd2);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_int", out_int, 32'd0);
    check("mid_rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_word", {31'd0, out_valid}, 32'd0);
    end
    push(32'hE0000000, 32'hE0000001, 1'b1);
    drain();

`ifdef STRUCT_SERIALIZER_CHECKSUM_EN
    // Checksum word: F0F0F0F0 ^ 0FF00FF0 = FF00FF00
    push(32'hF0F0F0F0, 32'h0FF00FF0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("csum_data", out_int, 32'hFF00FF00);
    check("csum_idx", {30'd0, out_idx}, 32'd2);
    check("csum_last", {31'd0, out_last}, 32'd1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
